// File: rtl/fouradder.sv
// 4-bit ripple-carry adder assembled from full-adder cells.
// Sum and carry-out are purely combinational.
module fouradder (
  output logic [3:0] S,
  output logic       Cout,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin
);

  // Returns {carry_out, sum} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  logic [4:0] carry_s;

  // Ripple the carry from bit 0 to bit 3.
  always_comb begin
    carry_s    = 5'd0;
    S          = 4'd0;
    carry_s[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      {carry_s[i+1], S[i]} = full_add(A[i], B[i], carry_s[i]);
    end
    Cout = carry_s[4];
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential 4x4 unsigned multiplier: one add-and-shift step per clock,
// four steps per product, using a single fouradder for the accumulation.
module shift_add_mult (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] P
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] m_q, m_d;
  logic [3:0] q_q, q_d;
  logic [3:0] acc_q, acc_d;
  logic       c_q, c_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] p_q, p_d;
  logic [3:0] sum_s;
  logic       cout_s;
  logic [4:0] pre_s;

  fouradder u_add (
    .S    (sum_s),
    .Cout (cout_s),
    .A    (acc_q),
    .B    (m_q),
    .Cin  (1'b0)
  );

  // All state: FSM, operands, accumulator, counter and product.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      m_q     <= 4'd0;
      q_q     <= 4'd0;
      acc_q   <= 4'd0;
      c_q     <= 1'b0;
      cnt_q   <= 3'd0;
      p_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Start) state_d = RUN;
        else       state_d = IDLE;
      end
      RUN: begin
        if (cnt_q == 3'd3) state_d = DONE;
        else               state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; the shifted-out carry lands in Acc[3], so C is
  // always 0 between RUN edges and the no-add branch keeps {C,Acc} as is.
  always_comb begin
    m_d   = m_q;
    q_d   = q_q;
    acc_d = acc_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    p_d   = p_q;
    pre_s = {c_q, acc_q};
    case (state_q)
      IDLE: begin
        if (Start) begin
          m_d   = A;
          q_d   = B;
          acc_d = 4'd0;
          c_d   = 1'b0;
          cnt_d = 3'd0;
        end else begin
          m_d   = m_q;
          q_d   = q_q;
        end
      end
      RUN: begin
        if (q_q[0]) pre_s = {cout_s, sum_s};
        else        pre_s = {c_q, acc_q};
        {c_d, acc_d, q_d} = {1'b0, pre_s, q_q[3:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) p_d = {acc_d, q_d};
        else               p_d = p_q;
      end
      DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = 3'd0;
      end
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (state_q)
      RUN:     Busy = 1'b1;
      DONE:    Done = 1'b1;
      default: begin
        Busy = 1'b0;
        Done = 1'b0;
      end
    endcase
  end

  assign P = p_q;

endmodule
